// File: rtl/out_port_arbiter.sv
// Purpose: wormhole arbiter for one router output link; grants one of
//          N_REQ input FIFOs round-robin and holds the grant for a whole
//          packet of PKT_FLITS flits.
// Latency: 1 cycle to arbitrate, then one flit/cycle; write_req/flit_out are
//          registered, so a flit reaches the link 1 cycle after its pop.
// Backpressure: neighbor_full or an empty owner FIFO stalls the transfer that
//          cycle (no pop, no write, counter frozen); the grant is never dropped.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   req              per-FIFO "head flit routes here" requests
//   flit_in          head flits, FIFO i at [i*FLIT_W +: FLIT_W]
//   neighbor_full    downstream FIFO full
//   pop              one-hot read strobe to the owning FIFO (combinational)
//   grant            registered one-hot owner, 0 when idle
//   write_req        registered downstream write strobe
//   flit_out         registered flit accompanying write_req
//   busy             a packet currently holds the port
module out_port_arbiter #(
  parameter int FLIT_W    = 4,
  parameter int N_REQ     = 5,
  parameter int PKT_FLITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*FLIT_W-1:0]   flit_in,
  input  logic                      neighbor_full,
  output logic [N_REQ-1:0]          pop,
  output logic [N_REQ-1:0]          grant,
  output logic                      write_req,
  output logic [FLIT_W-1:0]         flit_out,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_FLITS - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic               write_req_nxt;
  logic [FLIT_W-1:0]  flit_out_nxt;
  logic               busy_nxt;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [FLIT_W-1:0]  owner_flit;
  logic               transfer;

  // Round-robin pick: scan offsets from farthest to nearest so the last hit
  // written is the first set bit after ptr (ptr itself is checked last).
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      scan_idx = IDX_W'((int'(ptr) + off) % N_REQ);
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign owner_flit = flit_in[int'(owner)*FLIT_W +: FLIT_W];
  assign transfer   = (state == XFER) && req[owner] && !neighbor_full;
  assign pop        = transfer ? grant : '0;

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    busy_nxt      = busy;
    write_req_nxt = 1'b0;
    flit_out_nxt  = flit_out;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt = ONE << win_idx;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (transfer) begin
          write_req_nxt = 1'b1;
          flit_out_nxt  = owner_flit;
          if (cnt == CNT_LAST) begin
            // Finished owner drops to lowest priority for the next pick.
            cnt_nxt   = '0;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = owner;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      owner     <= '0;
      cnt       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      write_req <= 1'b0;
      flit_out  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      write_req <= write_req_nxt;
      flit_out  <= flit_out_nxt;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: two instances (PKT_FLITS=2 and PKT_FLITS=1)
// share stimulus; each is compared every cycle against a packet-level model.
module tb_out_port_arbiter;

  localparam int FW = 4;
  localparam int NR = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*FW-1:0]  flit_in;
  logic              neighbor_full;

  logic [NR-1:0] pop_a, grant_a, pop_b, grant_b;
  logic          write_req_a, busy_a, write_req_b, busy_b;
  logic [FW-1:0] flit_out_a, flit_out_b;

  always #5 clk = ~clk;

  out_port_arbiter #(.FLIT_W(FW), .N_REQ(NR), .PKT_FLITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .flit_in(flit_in),
    .neighbor_full(neighbor_full), .pop(pop_a), .grant(grant_a),
    .write_req(write_req_a), .flit_out(flit_out_a), .busy(busy_a));

  out_port_arbiter #(.FLIT_W(FW), .N_REQ(NR), .PKT_FLITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .flit_in(flit_in),
    .neighbor_full(neighbor_full), .pop(pop_b), .grant(grant_b),
    .write_req(write_req_b), .flit_out(flit_out_b), .busy(busy_b));

  // Model state per instance: owner index (-1 = nobody), flits sent in the
  // current packet, last finished owner, and the link output registers.
  int            pk[2] = '{2, 1};
  int            m_owner[2];
  int            m_sent[2];
  int            m_last[2];
  logic          m_wr[2];
  logic [FW-1:0] m_fo[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [FW-1:0] flit_of(input int idx);
    logic [NR*FW-1:0] f;
    f = flit_in;
    return f[idx*FW +: FW];
  endfunction

  function automatic logic [NR-1:0] exp_pop(input int m);
    if (m_owner[m] >= 0 && req[m_owner[m]] && !neighbor_full)
      return onehot(m_owner[m]);
    return '0;
  endfunction

  task automatic model_edge(input int m);
    if (!rst_n) begin
      m_owner[m] = -1; m_sent[m] = 0; m_last[m] = NR - 1;
      m_wr[m] = 1'b0;  m_fo[m] = '0;
    end else if (m_owner[m] < 0) begin
      m_wr[m] = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        if (m_owner[m] < 0 && req[(m_last[m] + k) % NR])
          m_owner[m] = (m_last[m] + k) % NR;
      end
    end else if (req[m_owner[m]] && !neighbor_full) begin
      m_wr[m] = 1'b1;
      m_fo[m] = flit_of(m_owner[m]);
      m_sent[m]++;
      if (m_sent[m] == pk[m]) begin
        m_sent[m] = 0; m_last[m] = m_owner[m]; m_owner[m] = -1;
      end
    end else begin
      m_wr[m] = 1'b0;
    end
  endtask

  // One clock: check combinational pop, clock, advance model, check registers.
  task automatic step();
    #1;
    chk("pop_a", 32'(pop_a), 32'(exp_pop(0)));
    chk("pop_b", 32'(pop_b), 32'(exp_pop(1)));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("grant_a", 32'(grant_a), 32'(onehot(m_owner[0])));
    chk("busy_a", 32'(busy_a), 32'(m_owner[0] >= 0));
    chk("write_req_a", 32'(write_req_a), 32'(m_wr[0]));
    chk("flit_out_a", 32'(flit_out_a), 32'(m_fo[0]));
    chk("grant_b", 32'(grant_b), 32'(onehot(m_owner[1])));
    chk("busy_b", 32'(busy_b), 32'(m_owner[1] >= 0));
    chk("write_req_b", 32'(write_req_b), 32'(m_wr[1]));
    chk("flit_out_b", 32'(flit_out_b), 32'(m_fo[1]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; neighbor_full = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_sent[m] = 0; m_last[m] = NR - 1;
      m_wr[m] = 1'b0;  m_fo[m] = '0;
    end
    rst_n = 1'b0; req = '0; flit_in = '0; neighbor_full = 1'b0;
    @(posedge clk);
    #1;

    // Single packet from local FIFO: flits A then B.
    do_reset();
    chk("reset_grant", 32'(grant_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    req = 5'b00001; flit_in = '0; flit_in[3:0] = 4'hA;
    step();
    chk("pkt1_grant", 32'(grant_a), 32'h01);
    step();
    chk("pkt1_flitA", 32'(flit_out_a), 32'hA);
    flit_in[3:0] = 4'hB;
    step();
    chk("pkt1_flitB", 32'(flit_out_a), 32'hB);
    chk("pkt1_idle", 32'(busy_a), 32'h0);
    req = '0;
    step();

    // All requesting: ten packets round-robin.
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 30; i++) begin
      flit_in = NR*FW'($urandom);
      step();
    end

    // Owner 2 stalled by neighbor_full for three cycles mid-packet.
    do_reset();
    req = 5'b00100;
    step(); step();
    neighbor_full = 1'b1;
    step(); step(); step();
    chk("stall_grant", 32'(grant_a), 32'h04);
    neighbor_full = 1'b0;
    step(); step();

    // Owner 3 underruns while FIFO 1 requests: lock holds.
    do_reset();
    req = 5'b01000;
    step(); step();
    req = 5'b00010;
    step(); step();
    chk("lock_grant", 32'(grant_a), 32'h08);
    req = 5'b01010;
    step(); step(); step(); step();

    // Reset mid-packet of owner 4, then 0 wins first.
    do_reset();
    req = 5'b10000;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 5'b10001;
    step();
    chk("post_rst_grant", 32'(grant_a), 32'h01);
    step(); step(); step();

    // Two requesters constant: alternation on the one-flit instance.
    do_reset();
    req = 5'b00110;
    for (int i = 0; i < 8; i++) step();

    // Random traffic with backpressure and occasional reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req           = NR'($urandom);
      flit_in       = NR*FW'($urandom);
      neighbor_full = ($urandom_range(0, 3) == 0);
      rst_n         = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
